// File: rtl/dmem_arbiter_if.sv
// Request/response and data-memory bundle between two requesters, the arbiter and the memory.
// Latency: none (wires only).
// Backpressure: the o_ReqReady/i_ReqValid pair per requester; responses cannot be stalled.
// Modports: slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32
);
  logic [1:0]                  i_ReqValid;
  logic [1:0]                  o_ReqReady;
  logic [2*MEM_ADDR_WIDTH-1:0] i_ReqAddr;
  logic [1:0]                  i_ReqWrEn;
  logic [7:0]                  i_ReqByteEn;
  logic [2*DATA_WIDTH-1:0]     i_ReqWData;
  logic [1:0]                  o_RspValid;
  logic [DATA_WIDTH-1:0]       o_RspRData;
  logic [MEM_ADDR_WIDTH-1:0]   o_MemAddr;
  logic [DATA_WIDTH-1:0]       o_MemDataIn;
  logic                        o_MemWrEn;
  logic [DATA_WIDTH-1:0]       i_MemDataOut;
  logic                        o_Busy;

  modport slave (
    input  i_ReqValid, i_ReqAddr, i_ReqWrEn, i_ReqByteEn, i_ReqWData, i_MemDataOut,
    output o_ReqReady, o_RspValid, o_RspRData, o_MemAddr, o_MemDataIn, o_MemWrEn, o_Busy
  );

  modport master (
    output i_ReqValid, i_ReqAddr, i_ReqWrEn, i_ReqByteEn, i_ReqWData, i_MemDataOut,
    input  o_ReqReady, o_RspValid, o_RspRData, o_MemAddr, o_MemDataIn, o_MemWrEn, o_Busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving two requesters serialized access to one single-port data memory.
// Latency: response 2 cycles after accept (load, full or empty store), 3 cycles for a partial store.
// Backpressure: o_ReqReady only in IDLE, to the round-robin winner; one transaction in flight.
// Ports: clk, reset_n (async active-low), bus (dmem_arbiter_if.slave: requests, responses, memory).
module dmem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32
) (
  input logic            clk,
  input logic            reset_n,
  dmem_arbiter_if.slave  bus
);
  localparam int AW = MEM_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wren_q, wren_d;
  logic [3:0]      be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;
  logic [1:0]      rsp_vld_q, rsp_vld_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  logic            win;
  logic [1:0]      grant;
  logic [DW-1:0]   merged;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    win = 1'b0;
    if (bus.i_ReqValid == 2'b11) win = ~last_q;
    else                         win = bus.i_ReqValid[1];
    grant = 2'b00;
    // Gated by reset_n so ready is low for the whole reset, not just after it.
    if (reset_n && state_q == IDLE && bus.i_ReqValid != 2'b00) grant = 2'b01 << win;
  end

  // Byte-lane merge of the store data over the word currently read from memory.
  always_comb begin
    merged = bus.i_MemDataOut;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    addr_d     = addr_q;
    wren_d     = wren_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    mem_addr_d = '0;
    mem_we_d   = 1'b0;
    mem_din_d  = '0;
    rsp_vld_d  = 2'b00;
    rsp_data_d = '0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          last_d     = win;
          id_d       = win;
          addr_d     = win ? bus.i_ReqAddr[2*AW-1:AW]   : bus.i_ReqAddr[AW-1:0];
          wren_d     = bus.i_ReqWrEn[win];
          be_d       = win ? bus.i_ReqByteEn[7:4]       : bus.i_ReqByteEn[3:0];
          wdata_d    = win ? bus.i_ReqWData[2*DW-1:DW]  : bus.i_ReqWData[DW-1:0];
          mem_addr_d = addr_d;
          // A full-word store writes during ACCESS, so its strobe is set up here.
          if (wren_d && be_d == 4'b1111) begin
            mem_we_d  = 1'b1;
            mem_din_d = wdata_d;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wren_q && be_q == 4'b1111) begin
          rsp_data_d = wdata_q;
          rsp_vld_d  = 2'b01 << id_q;
          state_d    = RESP;
        end else if (!wren_q || be_q == 4'b0000) begin
          rsp_data_d = bus.i_MemDataOut;
          rsp_vld_d  = 2'b01 << id_q;
          state_d    = RESP;
        end else begin
          mem_addr_d = addr_q;
          mem_we_d   = 1'b1;
          mem_din_d  = merged;
          state_d    = MERGE;
        end
      end
      MERGE: begin
        // The word being written is also the response word.
        rsp_data_d = mem_din_q;
        rsp_vld_d  = 2'b01 << id_q;
        state_d    = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      addr_q     <= '0;
      wren_q     <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
      rsp_vld_q  <= 2'b00;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      wren_q     <= wren_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.o_ReqReady  = grant;
  assign bus.o_RspValid  = rsp_vld_q;
  assign bus.o_RspRData  = rsp_data_q;
  assign bus.o_MemAddr   = mem_addr_q;
  assign bus.o_MemDataIn = mem_din_q;
  assign bus.o_MemWrEn   = mem_we_q;
  assign bus.o_Busy      = (state_q != IDLE);
endmodule
